// File: rtl/addsub_pkg.sv
// addsub_pkg: shared defaults and stage-count derivation for the pipelined adder/subtractor
package addsub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGE_W = 8;
  function automatic int nstg(input int width, input int stage_w);
    return width / stage_w;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit ripple slice with carry-out and MSB carry-in
module adder_slice import addsub_pkg::*; #(
  parameter int W = DEF_STAGE_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         msb_cin_o
);
  logic [W:0] c;
  assign c[0] = cin_i;
  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (.a_i(a_i[i]), .b_i(b_i[i]), .c_i(c[i]), .s_o(sum_o[i]), .c_o(c[i+1]));
  end
  assign cout_o = c[W];
  assign msb_cin_o = c[W-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGE_W bits resolved per stage, valid/ready handshake with global stall
module pipelined_addsub import addsub_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGE_W = DEF_STAGE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSTG = nstg(WIDTH, STAGE_W);
  if (STAGE_W < 1 || WIDTH < STAGE_W || WIDTH % STAGE_W != 0) begin : g_bad
    $error("WIDTH must be a positive multiple of STAGE_W");
  end
  logic [NSTG-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [NSTG-1:0]            c_q, c_d, v_q, v_d;
  logic                       ovf_q, ovf_d, adv;
  assign adv = !v_q[NSTG-1] || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [WIDTH-1:0]   ai, bi, si;
    logic [STAGE_W-1:0] ss;
    logic               ci, mc;
    // subtraction folds into an add here: B inverted, borrow-in becomes carry-in
    if (k == 0) begin : g_in
      assign ai = a;
      assign bi = sub ? ~b : b;
      assign si = '0;
      assign ci = cin ^ sub;
      assign v_d[k] = in_valid;
    end else begin : g_fwd
      assign ai = a_q[k-1];
      assign bi = b_q[k-1];
      assign si = s_q[k-1];
      assign ci = c_q[k-1];
      assign v_d[k] = v_q[k-1];
    end
    adder_slice #(.W(STAGE_W)) u_slice (
      .a_i(ai[k*STAGE_W +: STAGE_W]),
      .b_i(bi[k*STAGE_W +: STAGE_W]),
      .cin_i(ci),
      .sum_o(ss),
      .cout_o(c_d[k]),
      .msb_cin_o(mc)
    );
    assign a_d[k] = ai;
    assign b_d[k] = bi;
    assign s_d[k] = si | (WIDTH'(ss) << (k*STAGE_W));
    if (k == NSTG-1) begin : g_ovf
      assign ovf_d = mc ^ c_d[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      s_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_valid = v_q[NSTG-1];
  assign sum = s_q[NSTG-1];
  assign cout = c_q[NSTG-1];
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench with arithmetic reference model, directed and random traffic
module tb_pipelined_addsub;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic       in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic       out_valid, out_ready = 1'b0, cout, ovf;
  logic [7:0] a = '0, b = '0, sum;
  logic       v1 = 1'b0, r1, ov1, co1, of1;
  logic [7:0] s1;
  int checks = 0, errors = 0, n_out = 0;
  logic [9:0] exp_q[$];
  logic [9:0] prev_out = '0;
  logic       prev_stall = 1'b0;

  pipelined_addsub #(.WIDTH(8), .STAGE_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );
  pipelined_addsub #(.WIDTH(8), .STAGE_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(1'b1),
    .sum(s1), .cout(co1), .ovf(of1)
  );

  // Reference: unsigned result gives sum/cout, signed result range gives ovf
  function automatic logic [9:0] model(input logic [7:0] x, y, input logic c, s);
    int ru, rs;
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    if (!s) begin
      ru = int'(x) + int'(y) + int'(c);
      rs = sx + sy + int'(c);
    end else begin
      ru = int'(x) + (255 - int'(y)) + (1 - int'(c));
      rs = sx - sy - int'(c);
    end
    return {(rs < -128 || rs > 127), ru >= 256, ru[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lat(input logic [7:0] x, y, input logic c, s, output int lat);
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
      if (prev_stall) chk("stall_hold", {out_valid, ovf, cout, sum}, {1'b1, prev_out});
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no beat", {ovf, cout, sum});
        end else chk("result", {ovf, cout, sum}, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {ovf, cout, sum};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, sent, stall, base, acc;
    bit started;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_sum", {24'd0, sum}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    rst = 1'b0;
    send_lat(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    chk("lat_ff_01", lat, 2);
    chk("ff_01", {ovf, cout, sum}, {1'b0, 1'b1, 8'h00});
    tick();
    send_lat(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    chk("7f_01", {ovf, cout, sum}, {1'b1, 1'b0, 8'h80});
    tick();
    send_lat(8'h05, 8'h07, 1'b0, 1'b1, lat);
    chk("05_sub_07", {ovf, cout, sum}, {1'b0, 1'b0, 8'hFE});
    tick();
    a = 8'h80; b = 8'h80; cin = 1'b1; sub = 1'b0; v1 = 1'b1;
    chk("n1_pre_valid", {31'd0, ov1}, 0);
    tick();
    v1 = 1'b0;
    chk("n1_valid", {31'd0, ov1}, 1);
    chk("n1_result", {of1, co1, s1}, {1'b1, 1'b1, 8'h01});
    tick();
    sent = 0; stall = 0; started = 0; base = n_out;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!started && out_valid) begin
        started = 1;
        stall = 3;
      end
      out_ready = (stall == 0);
      in_valid = sent < 6;
      a = 8'(sent * 37 + 3); b = 8'(sent * 91); sub = sent[0]; cin = sent[1];
      @(negedge clk);
      if (stall > 0) begin
        chk("stall_in_ready", {31'd0, in_ready}, 0);
        stall--;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    chk("stall_count", n_out - base, 6);
    chk("stall_drained", exp_q.size(), 0);
    out_ready = 1'b0;
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 8'h33; b = 8'h44;
    tick();
    rst = 1'b1;
    a = 8'h55; b = 8'h66;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_result", {ovf, cout, sum}, 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_no_stale", {31'd0, out_valid}, 0);
    send_lat(8'h10, 8'h20, 1'b1, 1'b0, lat);
    chk("post_rst_lat", lat, 2);
    tick();
    acc = 0;
    for (int cyc = 0; acc < 10000 && cyc < 60000; cyc++) begin
      in_valid = $urandom_range(0, 3) != 0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      tick();
    end
    chk("random_beats", acc, 10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    chk("final_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: STAGE_W, 8, bits resolved per pipeline stage; WIDTH SHALL be a positive multiple of STAGE_W (elaboration error otherwise).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  operand beat offered.
REQ-006 Port: in_ready  output  1  block accepts beat this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: cin  input  1  carry-in (add) / borrow-in (sub).
REQ-010 Port: sub  input  1  0 = add, 1 = subtract.
REQ-011 Port: out_valid  output  1  result beat presented.
REQ-012 Port: out_ready  input  1  downstream accepts result.
REQ-013 Port: sum  output  WIDTH  result bits.
REQ-014 Port: cout  output  1  raw carry out of MSB.
REQ-015 Port: ovf  output  1  two's-complement signed overflow.

Function
REQ-016 NSTG = WIDTH/STAGE_W stages; stage k resolves bits [k*STAGE_W +: STAGE_W] using the carry registered by stage k-1.
REQ-017 Add: {cout,sum} = a + b + cin; sub: {cout,sum} = a + ~b + ~cin (cin acts as borrow-in; cout = 1 means no borrow).
REQ-018 ovf = carry into MSB XOR cout, computed in the final stage.
REQ-019 Beat accepted when in_valid && in_ready; unstalled latency from accept to out_valid is exactly NSTG cycles.
REQ-020 Transfer out when out_valid && out_ready; full throughput one beat per cycle when out_ready held high.
REQ-021 Stall: pipeline advances iff !out_valid || out_ready; in_ready SHALL equal that term (combinational, no dependence on in_valid).
REQ-022 While stalled, sum/cout/ovf/out_valid and all stage registers SHALL hold; no beat dropped or duplicated.
REQ-023 Bubbles: each stage carries its own valid bit; empty stages advance regardless of downstream occupancy only via the global advance term (no per-stage bubble collapse).
REQ-024 Results leave in acceptance order.
REQ-025 Operand bits not yet resolved SHALL be delayed alongside the stage; sub SHALL be applied once at stage 0 (B inverted, carry-in mapped).
REQ-026 NSTG = 1 SHALL degenerate to a single registered adder, latency 1.

Reset
REQ-027 On rst high at a clock edge: all stage valid bits, out_valid, sum, cout, ovf cleared to 0; in_ready = 1 in the following cycle.
REQ-028 Reset mid-operation discards all in-flight beats; none SHALL appear on the output afterwards.
REQ-029 A beat offered in the same cycle as rst SHALL NOT be accepted.

Structure
REQ-030 Package addsub_pkg SHALL hold default WIDTH/STAGE_W constants and the NSTG derivation function.
REQ-031 One sub-module adder_slice SHALL implement the combinational STAGE_W-bit ripple slice (a, b, cin -> sum, cout, msb carry-in) built from the existing full_adder cell; pipelined_addsub instantiates it NSTG times via generate.
REQ-032 Stage registers and handshake logic SHALL live in pipelined_addsub only.

Verification (WIDTH=8, STAGE_W=4, NSTG=2)
REQ-033 a=0xFF b=0x01 cin=0 sub=0, out_ready=1 -> out_valid exactly 2 cycles after accept, sum=0x00 cout=1 ovf=0.
REQ-034 a=0x7F b=0x01 cin=0 sub=0 -> sum=0x80 cout=0 ovf=1; a=0x05 b=0x07 cin=0 sub=1 -> sum=0xFE cout=0 ovf=0.
REQ-035 Stream 6 beats back-to-back, out_ready low for 3 cycles once out_valid rises -> in_ready low those cycles, output held stable, all 6 results emerge in order, none lost.
REQ-036 Two beats in flight, rst high 1 cycle -> out_valid=0, sum=0 after edge; no stale result ever appears; next beat after reset has latency 2.
REQ-037 Re-elaborate WIDTH=8 STAGE_W=8: a=0x80 b=0x80 sub=0 cin=1 -> latency 1, sum=0x01 cout=1 ovf=1.
REQ-038 Random constrained stream with random out_ready, both modes, compared against a reference model -> zero mismatches over 10k beats.
